// File: rtl/jk_pkg.sv
// Shared types and helpers for the JK command sequencer: FSM encoding, JK op codes
// and the next-state rule of an ideal JK flip-flop.
package jk_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_DRIVE = 1'b1
   } state_t;

   localparam logic [1:0] JK_HOLD = 2'b00;
   localparam logic [1:0] JK_RST  = 2'b01;
   localparam logic [1:0] JK_SET  = 2'b10;
   localparam logic [1:0] JK_TGL  = 2'b11;

   typedef struct packed {
      logic j;
      logic k;
   } jk_pair_t;

   function automatic logic jk_next(input logic q, input logic [1:0] op);
      logic nq;
      case (op)
         JK_HOLD: nq = q;
         JK_RST:  nq = 1'b0;
         JK_SET:  nq = 1'b1;
         default: nq = ~q;
      endcase
      return nq;
   endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// Synchronous FIFO with one extra pointer bit so full and empty are distinguishable
// without a separate occupancy counter. Push while full and pop while empty are ignored.
module jk_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int ADDR_W = $clog2(DEPTH);
   localparam int PTR_W  = ADDR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                    (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
   assign empty   = (wr_ptr == rd_ptr);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr[ADDR_W-1:0]];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
   end

   // Storage carries no reset; the pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[ADDR_W-1:0]] <= din;
   end

endmodule

// File: rtl/jk_cmd_sequencer.sv
// Queues (j, k, hold) commands, drives a JK flop's inputs for each hold period and
// checks the flop's q against an internal reference, latching any divergence.
module jk_cmd_sequencer
   import jk_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int HOLD_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_j,
   input  logic              cmd_k,
   input  logic [HOLD_W-1:0] cmd_hold,
   output logic              j,
   output logic              k,
   input  logic              q_in,
   output logic              step_done,
   output logic              busy,
   output logic              mismatch,
   input  logic              mismatch_clr
);

   typedef struct packed {
      jk_pair_t          jk;
      logic [HOLD_W-1:0] hold;
   } cmd_t;

   localparam int CMD_W = $bits(cmd_t);

   state_t            state;
   state_t            state_nxt;
   logic [HOLD_W-1:0] cnt;
   logic [HOLD_W-1:0] cnt_nxt;
   logic              j_nxt;
   logic              k_nxt;
   logic              push;
   logic              pop;
   logic              full;
   logic              empty;
   logic              q_pred;
   cmd_t              push_cmd;
   cmd_t              head;
   logic [CMD_W-1:0]  head_bits;

   // A zero hold is promoted to one so every command occupies at least one cycle.
   function automatic logic [HOLD_W-1:0] hold_load(input logic [HOLD_W-1:0] h);
      return (h == '0) ? HOLD_W'(1) : h;
   endfunction

   assign push      = cmd_valid && !full;
   assign cmd_ready = !full;
   assign push_cmd  = {cmd_j, cmd_k, cmd_hold};
   assign head      = cmd_t'(head_bits);
   assign busy      = (state == ST_DRIVE) || !empty;

   jk_cmd_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (CMD_W)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .din   (push_cmd),
      .pop   (pop),
      .dout  (head_bits),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
         cnt   <= '0;
         j     <= 1'b0;
         k     <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         j     <= j_nxt;
         k     <= k_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      j_nxt     = j;
      k_nxt     = k;
      pop       = 1'b0;
      step_done = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!empty) begin
               pop       = 1'b1;
               j_nxt     = head.jk.j;
               k_nxt     = head.jk.k;
               cnt_nxt   = hold_load(head.hold);
               state_nxt = ST_DRIVE;
            end
         end
         ST_DRIVE: begin
            if (cnt == HOLD_W'(1)) begin
               step_done = 1'b1;
               // Reload on the closing edge so consecutive commands abut without a gap.
               if (!empty) begin
                  pop     = 1'b1;
                  j_nxt   = head.jk.j;
                  k_nxt   = head.jk.k;
                  cnt_nxt = hold_load(head.hold);
               end else begin
                  j_nxt     = 1'b0;
                  k_nxt     = 1'b0;
                  cnt_nxt   = '0;
                  state_nxt = ST_IDLE;
               end
            end else begin
               cnt_nxt = cnt - HOLD_W'(1);
            end
         end
      endcase
   end

   // Reference flop samples the same registered j/k as the real flop, so both
   // should present identical q between edges.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_pred   <= 1'b0;
         mismatch <= 1'b0;
      end else begin
         q_pred <= jk_next(q_pred, {j, k});
         if (q_in != q_pred) mismatch <= 1'b1;
         else if (mismatch_clr) mismatch <= 1'b0;
      end
   end

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Randomized and directed bench for jk_cmd_sequencer against a timeline model of
// command start/end edges.
module tb_jk_cmd_sequencer;

   localparam int DEPTH  = 4;
   localparam int HOLD_W = 8;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              cmd_valid = 1'b0;
   logic              cmd_ready;
   logic              cmd_j = 1'b0;
   logic              cmd_k = 1'b0;
   logic [HOLD_W-1:0] cmd_hold = '0;
   logic              j;
   logic              k;
   logic              q_in;
   logic              step_done;
   logic              busy;
   logic              mismatch;
   logic              mismatch_clr = 1'b0;

   logic              flop_q;
   logic              stuck_en = 1'b0;
   logic              stuck_val = 1'b0;

   jk_cmd_sequencer #(
      .DEPTH  (DEPTH),
      .HOLD_W (HOLD_W)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_j        (cmd_j),
      .cmd_k        (cmd_k),
      .cmd_hold     (cmd_hold),
      .j            (j),
      .k            (k),
      .q_in         (q_in),
      .step_done    (step_done),
      .busy         (busy),
      .mismatch     (mismatch),
      .mismatch_clr (mismatch_clr)
   );

   always #5 clk = ~clk;

   // Stand-in for the downstream flop, written from its characteristic equation.
   always @(posedge clk or posedge reset) begin
      if (reset) flop_q <= 1'b0;
      else       flop_q <= (j & ~flop_q) | (~k & flop_q);
   end

   assign q_in = stuck_en ? stuck_val : flop_q;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int p;
      int start;
      int fin;
      bit cj;
      bit ck;
   } cmd_rec_t;

   cmd_rec_t cmds[$];
   int       last_fin = 0;
   bit       q_m = 1'b0;
   bit       mism_m = 1'b0;
   int       n_vec = 0;
   int       n_err = 0;

   task automatic check(input string tag, input int got, input int want);
      n_vec++;
      if (got != want) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%0d want=%0d", tag, cyc, got, want);
      end
   endtask

   // One cycle: check the outputs for the current cycle, then drive inputs for the
   // next edge and advance the model past that edge.
   task automatic step(input bit v, input bit cj, input bit ck, input int h,
                       input bit clr, input bit stk, input bit sv);
      int  c;
      int  occ;
      bit  ej, ek, sd, bz, rdy, qin_now;
      cmd_rec_t r;
      c = cyc;
      while (cmds.size() > 0 && cmds[0].fin <= c) void'(cmds.pop_front());
      ej = 0; ek = 0; sd = 0; bz = 0; occ = 0;
      foreach (cmds[i]) begin
         if (cmds[i].start <= c && c < cmds[i].fin) begin
            ej = cmds[i].cj;
            ek = cmds[i].ck;
         end
         if (cmds[i].fin == c + 1) sd = 1;
         if (cmds[i].p <= c && c < cmds[i].fin) bz = 1;
         if (cmds[i].p <= c && c < cmds[i].start) occ++;
      end
      rdy = (occ < DEPTH);
      check("j", int'(j), int'(ej));
      check("k", int'(k), int'(ek));
      check("step_done", int'(step_done), int'(sd));
      check("busy", int'(busy), int'(bz));
      check("cmd_ready", int'(cmd_ready), int'(rdy));
      check("mismatch", int'(mismatch), int'(mism_m));

      cmd_valid    = v;
      cmd_j        = cj;
      cmd_k        = ck;
      cmd_hold     = HOLD_W'(h);
      mismatch_clr = clr;
      stuck_en     = stk;
      stuck_val    = sv;
      qin_now      = stk ? sv : flop_q;

      if (v && rdy) begin
         r.p     = c + 1;
         r.start = (c + 2 > last_fin) ? c + 2 : last_fin;
         r.fin   = r.start + ((h == 0) ? 1 : h);
         r.cj    = cj;
         r.ck    = ck;
         last_fin = r.fin;
         cmds.push_back(r);
      end
      if (qin_now != q_m) mism_m = 1;
      else if (clr)       mism_m = 0;
      if (ej && ek)       q_m = !q_m;
      else if (ej)        q_m = 1;
      else if (ek)        q_m = 0;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      cmd_valid = 0; mismatch_clr = 0; stuck_en = 0;
      reset = 1;
      #1;
      check("rst_j", int'(j), 0);
      check("rst_k", int'(k), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_ready", int'(cmd_ready), 1);
      check("rst_step_done", int'(step_done), 0);
      check("rst_mismatch", int'(mismatch), 0);
      cmds.delete();
      last_fin = 0;
      q_m = 0;
      mism_m = 0;
      @(negedge clk);
      @(negedge clk);
      reset = 0;
   endtask

   function automatic int rand_hold();
      int r;
      r = $urandom_range(0, 99);
      if (r < 6)  return 0;
      if (r < 7)  return 255;
      if (r < 9)  return $urandom_range(10, 30);
      return $urandom_range(1, 5);
   endfunction

   initial begin
      bit stk, sv;
      #2;
      do_reset();

      // single set command, hold 3
      step(1, 1, 0, 3, 0, 0, 0);
      idle(6);

      // fill the FIFO and offer a fifth
      for (int i = 0; i < 5; i++) step(1, i[0], i[1], 2 + i, 0, 0, 0);
      idle(25);

      // toggle with a stuck-at-0 q, clear attempts while disagreeing and after
      step(1, 1, 1, 4, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 1, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0, 0);
      idle(3);

      // hold of zero behaves as one
      step(1, 1, 0, 0, 0, 0, 0);
      idle(4);

      // reset in the middle of a long step with two commands queued
      step(1, 1, 0, 10, 0, 0, 0);
      step(1, 0, 1, 3, 0, 0, 0);
      step(1, 1, 1, 3, 0, 0, 0);
      idle(1);
      do_reset();
      idle(20);

      // reset then hold low
      step(1, 0, 1, 2, 0, 0, 0);
      step(1, 0, 0, 2, 0, 0, 0);
      idle(6);

      // maximum hold count
      step(1, 1, 1, 255, 0, 0, 0);
      step(1, 0, 1, 1, 0, 0, 0);
      idle(262);

      stk = 0; sv = 0;
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(0, 299) == 0) begin
            do_reset();
            stk = 0;
         end else begin
            if ($urandom_range(0, 59) == 0) begin
               stk = !stk;
               sv  = 1'($urandom_range(0, 1));
            end
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), rand_hold(),
                 ($urandom_range(0, 7) == 0), stk, sv);
         end
      end
      idle(300);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
